// File: rtl/constraint_sampler.sv
// constraint_sampler: proposes LFSR-derived candidates to an external constraint
// checker and streams out the candidates for which every checker flag is high.
module constraint_sampler #(
  parameter int unsigned NUM_CONS  = 8,
  parameter logic [63:0] SEED      = 64'hACE1_2468_1357_9BDF,
  parameter int unsigned MAX_TRIES = 1024,
  parameter int unsigned CHECK_LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         num_samples,
  output logic [12:0]         cand_var_0,
  output logic [12:0]         cand_var_1,
  output logic [13:0]         cand_var_2,
  output logic [13:0]         cand_var_3,
  output logic [7:0]          cand_var_4,
  input  logic [NUM_CONS-1:0] cons_in,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [61:0]         sample_var,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [15:0]         tries_out
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [63:0] SEED_EFF = (SEED == '0) ? 64'h1 : SEED;
  // Galois feedback for x^64+x^63+x^61+x^60+1 in right-shift form.
  localparam logic [63:0] TAP_MASK = 64'hD800_0000_0000_0000;
  localparam int unsigned WAIT_W   = (CHECK_LAT > 0) ? $clog2(CHECK_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CHECK_LAT);
  localparam logic [15:0] TRY_LAST = 16'(MAX_TRIES - 1);
  localparam logic [15:0] TRY_FAIL = 16'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROPOSE,
    S_CHECK,
    S_EMIT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [63:0]       lfsr;
  logic [63:0]       lfsr_step;
  logic [15:0]       cnt;
  logic [15:0]       tries;
  logic [15:0]       num_lat;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              last_sample;

  assign lfsr_step   = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? TAP_MASK : '0);
  assign accept      = &cons_in;
  assign last_sample = (cnt == num_lat - 16'd1);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign fail = (state == S_FAIL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (num_samples == '0) ? S_DONE : S_PROPOSE;
        end
      end
      S_PROPOSE: state_next = S_CHECK;
      S_CHECK: begin
        if (wait_cnt == '0) begin
          if (accept) begin
            state_next = S_EMIT;
          end else if (tries == TRY_LAST) begin
            state_next = S_FAIL;
          end else begin
            state_next = S_PROPOSE;
          end
        end
      end
      S_EMIT: begin
        if (sample_ready) begin
          state_next = last_sample ? S_DONE : S_PROPOSE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_FAIL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: LFSR, candidate registers, counters and the output sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr         <= SEED_EFF;
      cand_var_0   <= '0;
      cand_var_1   <= '0;
      cand_var_2   <= '0;
      cand_var_3   <= '0;
      cand_var_4   <= '0;
      sample_valid <= 1'b0;
      sample_var   <= '0;
      tries_out    <= '0;
      cnt          <= '0;
      tries        <= '0;
      num_lat      <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_lat <= num_samples;
            cnt     <= '0;
            tries   <= '0;
          end
        end
        S_PROPOSE: begin
          cand_var_0 <= lfsr[12:0];
          cand_var_1 <= lfsr[25:13];
          cand_var_2 <= lfsr[39:26];
          cand_var_3 <= lfsr[53:40];
          cand_var_4 <= lfsr[61:54];
          lfsr       <= lfsr_step;
          wait_cnt   <= WAIT_INIT;
        end
        S_CHECK: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (accept) begin
            sample_var   <= {cand_var_4, cand_var_3, cand_var_2, cand_var_1, cand_var_0};
            sample_valid <= 1'b1;
            tries_out    <= tries + 16'd1;
          end else if (tries == TRY_LAST) begin
            tries_out <= TRY_FAIL;
          end else begin
            tries <= tries + 16'd1;
          end
        end
        S_EMIT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            tries        <= '0;
            if (!last_sample) begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
